// File: rtl/mem_pkg.sv
// Shared opcodes, FSM state encoding and access-owner codes for the data-memory arbiter.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the arbiter, its round-robin sub-block and the bench.
package mem_pkg;
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    typedef struct packed {
        owner_t     owner;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    function automatic logic [2:0] op_for(input logic we);
        return we ? OP_SW : OP_LW;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (core, DMA) and memory-side signals of the data-memory arbiter.
// Wires only; no latency.
// Requesters hold req until their one-cycle ack; the memory answers by toggling mem_signal.
interface mem_arbiter_if;
    logic       core_req;
    logic       core_we;
    logic [7:0] core_addr;
    logic [7:0] core_wdata;
    logic       core_ack;
    logic [7:0] core_rdata;

    logic       dma_req;
    logic       dma_we;
    logic [7:0] dma_addr;
    logic [7:0] dma_wdata;
    logic       dma_ack;
    logic [7:0] dma_rdata;

    logic [2:0] mem_instruction;
    logic [7:0] mem_reg_alpha;
    logic [7:0] mem_reg_beta;
    logic [7:0] mem_data_in;
    logic       mem_signal;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_ack, core_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_instruction, mem_reg_alpha, mem_reg_beta,
        output mem_data_in, mem_signal
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_ack, core_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_instruction, mem_reg_alpha, mem_reg_beta,
        input  mem_data_in, mem_signal
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way core/DMA grant with optional fixed core priority; rr_last is the only state.
// Grant is combinational from req; rr_last updates on the clock edge that accepts a grant.
// No backpressure: the caller decides when a grant is taken via gnt_en.
module rr_arbiter2
    import mem_pkg::*;
#(
    parameter bit CORE_PRIORITY = 1'b0
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   core_req,
    input  logic   dma_req,
    input  logic   gnt_en,
    output logic   gnt_vld,
    output owner_t gnt_owner
);
    owner_t rr_last_q, rr_last_d;

    always_comb begin
        gnt_vld   = core_req | dma_req;
        gnt_owner = OWN_CORE;
        if (core_req && dma_req) begin
            // On a tie, round-robin hands the grant to whoever did not win last time
            if (!CORE_PRIORITY && rr_last_q == OWN_CORE) begin
                gnt_owner = OWN_DMA;
            end
        end else if (dma_req) begin
            gnt_owner = OWN_DMA;
        end
        rr_last_d = (gnt_en && gnt_vld) ? gnt_owner : rr_last_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q <= OWN_DMA;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Sequences one core/DMA access at a time into the slow toggle-handshake data memory.
// Latency: ack 3 cycles after req plus the WAIT cycles before the done toggle; timeout after TIMEOUT_CYCLES+1 WAIT cycles.
// Requesters hold req until ack; a losing or non-owner request simply waits in place.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit CORE_PRIORITY  = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          timeout_err
);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    state_t     state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic       sig_q, sig_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] core_rdata_q, core_rdata_d;
    logic [7:0] dma_rdata_q, dma_rdata_d;
    logic       terr_q, terr_d;

    logic       gnt_vld;
    owner_t     gnt_owner;
    logic       toggled;
    logic       expired;
    logic [7:0] rsp_dat;

    rr_arbiter2 #(.CORE_PRIORITY(CORE_PRIORITY)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .core_req  (bus.core_req),
        .dma_req   (bus.dma_req),
        .gnt_en    (state_q == S_IDLE),
        .gnt_vld   (gnt_vld),
        .gnt_owner (gnt_owner)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        sig_d        = sig_q;
        cnt_d        = cnt_q;
        core_rdata_d = core_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        terr_d       = terr_q;
        toggled      = (bus.mem_signal != sig_q);
        expired      = !toggled && (cnt_q == TO_LIM);
        rsp_dat      = expired ? 8'h00 : bus.mem_data_in;

        case (state_q)
            S_IDLE: begin
                // Stray toggles while idle are absorbed by re-sampling every cycle
                sig_d = bus.mem_signal;
                if (gnt_vld) begin
                    state_d     = S_ISSUE;
                    cmd_d.owner = gnt_owner;
                    if (gnt_owner == OWN_DMA) begin
                        cmd_d.we    = bus.dma_we;
                        cmd_d.addr  = bus.dma_addr;
                        cmd_d.wdata = bus.dma_wdata;
                    end else begin
                        cmd_d.we    = bus.core_we;
                        cmd_d.addr  = bus.core_addr;
                        cmd_d.wdata = bus.core_wdata;
                    end
                end
            end
            S_ISSUE: begin
                sig_d   = bus.mem_signal;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (toggled || expired) begin
                    state_d = S_RESP;
                    terr_d  = terr_q | expired;
                    if (!cmd_q.we) begin
                        if (cmd_q.owner == OWN_DMA) begin
                            dma_rdata_d = rsp_dat;
                        end else begin
                            core_rdata_d = rsp_dat;
                        end
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            sig_q        <= bus.mem_signal;
            cnt_q        <= '0;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            sig_q        <= sig_d;
            cnt_q        <= cnt_d;
            core_rdata_q <= core_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            terr_q       <= terr_d;
        end
    end

    assign bus.mem_instruction = (state_q == S_ISSUE) ? op_for(cmd_q.we) : OP_NOP;
    assign bus.mem_reg_alpha   = cmd_q.wdata;
    assign bus.mem_reg_beta    = cmd_q.addr;
    assign bus.core_ack        = (state_q == S_RESP) && (cmd_q.owner == OWN_CORE);
    assign bus.dma_ack         = (state_q == S_RESP) && (cmd_q.owner == OWN_DMA);
    assign bus.core_rdata      = core_rdata_q;
    assign bus.dma_rdata       = dma_rdata_q;
    assign busy                = (state_q != S_IDLE);
    assign timeout_err         = terr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with a toggle-handshake memory model
// and a fixed-priority instance with a minimal one-cycle responder.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic busy_rr, terr_rr, busy_fp, terr_fp;
    mem_arbiter_if bus_rr ();
    mem_arbiter_if bus_fp ();

    mem_arbiter #(.TIMEOUT_CYCLES(16), .CORE_PRIORITY(1'b0)) u_rr (
        .clock(clock), .reset(reset), .bus(bus_rr), .busy(busy_rr), .timeout_err(terr_rr));
    mem_arbiter #(.TIMEOUT_CYCLES(16), .CORE_PRIORITY(1'b1)) u_fp (
        .clock(clock), .reset(reset), .bus(bus_fp), .busy(busy_fp), .timeout_err(terr_fp));

    // Memory model for the round-robin instance: answers mem_delay negedges after seeing ISSUE.
    // Unwritten locations read back as addr ^ 8'h5A.
    logic       rr_sig = 1'b0;
    logic [7:0] rr_din = 8'h00;
    assign bus_rr.mem_signal  = rr_sig;
    assign bus_rr.mem_data_in = rr_din;
    int         mem_delay = 2;
    bit         mem_en    = 1'b1;
    int         spur_req  = 0;
    int         spur_seen = 0;
    int         pend_cnt  = 0;
    logic [7:0] pend_dat  = 8'h00;
    logic [7:0] mem_arr [256];
    bit         mem_wr  [256];

    always @(negedge clock) begin
        if (spur_req != spur_seen) begin
            spur_seen = spur_req;
            rr_sig    = ~rr_sig;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0 && mem_en) begin
                rr_din = pend_dat;
                rr_sig = ~rr_sig;
            end
        end
        if (bus_rr.mem_instruction == OP_SW) begin
            mem_arr[bus_rr.mem_reg_beta] = bus_rr.mem_reg_alpha;
            mem_wr[bus_rr.mem_reg_beta]  = 1'b1;
            pend_dat = 8'h00;
            pend_cnt = mem_delay;
        end else if (bus_rr.mem_instruction == OP_LW) begin
            pend_dat = mem_wr[bus_rr.mem_reg_beta] ? mem_arr[bus_rr.mem_reg_beta]
                                                   : (bus_rr.mem_reg_beta ^ 8'h5A);
            pend_cnt = mem_delay;
        end
    end

    logic fp_sig  = 1'b0;
    bit   fp_seen = 1'b0;
    assign bus_fp.mem_signal  = fp_sig;
    assign bus_fp.mem_data_in = 8'h00;
    always @(negedge clock) begin
        if (fp_seen) begin
            fp_sig  = ~fp_sig;
            fp_seen = 1'b0;
        end
        if (bus_fp.mem_instruction != OP_NOP) fp_seen = 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int         lat, n_sw, n_lw, other_acks;
    bit         got_ack;
    logic [7:0] iss_addr, iss_wdata, rd;

    // One access on the round-robin instance; lat counts cycles from req to the ack cycle.
    task automatic access(input string tag, input bit is_dma, input bit we,
                          input logic [7:0] addr, input logic [7:0] wdata, input int limit);
        lat = 0; n_sw = 0; n_lw = 0; other_acks = 0; got_ack = 1'b0;
        if (is_dma) begin
            bus_rr.dma_req = 1'b1; bus_rr.dma_we = we; bus_rr.dma_addr = addr; bus_rr.dma_wdata = wdata;
        end else begin
            bus_rr.core_req = 1'b1; bus_rr.core_we = we; bus_rr.core_addr = addr; bus_rr.core_wdata = wdata;
        end
        while (!got_ack && lat < limit) begin
            tick();
            lat++;
            if (bus_rr.mem_instruction == OP_SW) n_sw++;
            if (bus_rr.mem_instruction == OP_LW) n_lw++;
            if (bus_rr.mem_instruction != OP_NOP) begin
                iss_addr  = bus_rr.mem_reg_beta;
                iss_wdata = bus_rr.mem_reg_alpha;
            end
            if (is_dma ? bus_rr.core_ack : bus_rr.dma_ack) other_acks++;
            if (is_dma ? bus_rr.dma_ack : bus_rr.core_ack) begin
                got_ack = 1'b1;
                rd = is_dma ? bus_rr.dma_rdata : bus_rr.core_rdata;
            end
        end
        check({tag, "_ack_seen"}, 32'(got_ack), 32'd1);
        bus_rr.core_req = 1'b0;
        bus_rr.dma_req  = 1'b0;
        tick();
    endtask

    int order[$];
    int ack_cyc[$];
    int both, cyc, fc, fd, stray_ack, stray_busy;

    initial begin
        reset = 1'b1;
        bus_rr.core_req = 1'b0; bus_rr.core_we = 1'b0; bus_rr.core_addr = 8'h00; bus_rr.core_wdata = 8'h00;
        bus_rr.dma_req  = 1'b0; bus_rr.dma_we  = 1'b0; bus_rr.dma_addr  = 8'h00; bus_rr.dma_wdata  = 8'h00;
        bus_fp.core_req = 1'b0; bus_fp.core_we = 1'b0; bus_fp.core_addr = 8'h00; bus_fp.core_wdata = 8'h00;
        bus_fp.dma_req  = 1'b0; bus_fp.dma_we  = 1'b0; bus_fp.dma_addr  = 8'h00; bus_fp.dma_wdata  = 8'h00;
        repeat (3) tick();

        check("rst_core_ack",   32'(bus_rr.core_ack), 32'd0);
        check("rst_dma_ack",    32'(bus_rr.dma_ack), 32'd0);
        check("rst_core_rdata", 32'(bus_rr.core_rdata), 32'h00);
        check("rst_dma_rdata",  32'(bus_rr.dma_rdata), 32'h00);
        check("rst_instr",      32'(bus_rr.mem_instruction), 32'(OP_NOP));
        check("rst_alpha",      32'(bus_rr.mem_reg_alpha), 32'h00);
        check("rst_beta",       32'(bus_rr.mem_reg_beta), 32'h00);
        check("rst_busy",       32'(busy_rr), 32'd0);
        check("rst_terr",       32'(terr_rr), 32'd0);
        reset = 1'b0;
        tick();

        // Core store then load, memory toggles two cycles after ISSUE
        access("core_sw", 1'b0, 1'b1, 8'h10, 8'hA5, 30);
        check("sw_latency", 32'(lat), 32'd4);
        check("sw_issue_cnt", 32'(n_sw), 32'd1);
        check("sw_no_lw", 32'(n_lw), 32'd0);
        check("sw_addr", 32'(iss_addr), 32'h10);
        check("sw_wdata", 32'(iss_wdata), 32'hA5);
        check("sw_rdata_kept", 32'(rd), 32'h00);
        check("sw_other_ack", 32'(other_acks), 32'd0);
        access("core_lw", 1'b0, 1'b0, 8'h10, 8'h00, 30);
        check("lw_latency", 32'(lat), 32'd4);
        check("lw_issue_cnt", 32'(n_lw), 32'd1);
        check("lw_rdata", 32'(rd), 32'hA5);

        // Both requesters held high: grants alternate starting with core
        reset = 1'b1; tick(); reset = 1'b0;
        bus_rr.core_req = 1'b1; bus_rr.core_we = 1'b0; bus_rr.core_addr = 8'h10;
        bus_rr.dma_req  = 1'b1; bus_rr.dma_we  = 1'b0; bus_rr.dma_addr  = 8'h20;
        both = 0; cyc = 0;
        while (order.size() < 4 && cyc < 80) begin
            tick();
            cyc++;
            if (bus_rr.core_ack && bus_rr.dma_ack) both++;
            if (bus_rr.core_ack) begin order.push_back(0); ack_cyc.push_back(cyc); end
            if (bus_rr.dma_ack)  begin order.push_back(1); ack_cyc.push_back(cyc); end
        end
        bus_rr.core_req = 1'b0; bus_rr.dma_req = 1'b0;
        tick();
        check("rr_ack_count", 32'(order.size()), 32'd4);
        check("rr_both_acks", 32'(both), 32'd0);
        if (order.size() == 4) begin
            check("rr_grant0", 32'(order[0]), 32'd0);
            check("rr_grant1", 32'(order[1]), 32'd1);
            check("rr_grant2", 32'(order[2]), 32'd0);
            check("rr_grant3", 32'(order[3]), 32'd1);
            check("rr_first_ack", 32'(ack_cyc[0]), 32'd4);
            for (int i = 1; i < 4; i++) check("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
        end
        check("rr_core_rdata", 32'(bus_rr.core_rdata), 32'hA5);
        check("rr_dma_rdata", 32'(bus_rr.dma_rdata), 32'h7A);

        // Fixed priority instance: core starves DMA
        bus_fp.core_req = 1'b1; bus_fp.core_addr = 8'h01;
        bus_fp.dma_req  = 1'b1; bus_fp.dma_addr  = 8'h02;
        fc = 0; fd = 0; cyc = 0;
        while (fc < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (bus_fp.core_ack) fc++;
            if (bus_fp.dma_ack) fd++;
        end
        bus_fp.core_req = 1'b0; bus_fp.dma_req = 1'b0;
        tick();
        check("fp_core_acks", 32'(fc), 32'd3);
        check("fp_dma_acks", 32'(fd), 32'd0);

        // Memory never answers: timeout, sticky error, next access still serviced
        mem_en = 1'b0;
        access("core_to", 1'b0, 1'b0, 8'h30, 8'h00, 40);
        check("to_latency", 32'(lat), 32'd19);
        check("to_rdata", 32'(rd), 32'h00);
        check("to_err_set", 32'(terr_rr), 32'd1);
        mem_en = 1'b1;
        access("after_to", 1'b0, 1'b0, 8'h10, 8'h00, 30);
        check("after_to_latency", 32'(lat), 32'd4);
        check("after_to_rdata", 32'(rd), 32'hA5);
        check("to_err_sticky", 32'(terr_rr), 32'd1);

        // Reset while a DMA load sits in WAIT
        mem_delay = 6;
        bus_rr.dma_req = 1'b1; bus_rr.dma_we = 1'b0; bus_rr.dma_addr = 8'h20;
        repeat (3) tick();
        check("mid_busy", 32'(busy_rr), 32'd1);
        reset = 1'b1;
        tick();
        bus_rr.dma_req = 1'b0;
        check("mrst_dma_ack", 32'(bus_rr.dma_ack), 32'd0);
        check("mrst_busy", 32'(busy_rr), 32'd0);
        check("mrst_terr", 32'(terr_rr), 32'd0);
        check("mrst_core_rdata", 32'(bus_rr.core_rdata), 32'h00);
        check("mrst_dma_rdata", 32'(bus_rr.dma_rdata), 32'h00);
        check("mrst_instr", 32'(bus_rr.mem_instruction), 32'(OP_NOP));
        check("mrst_beta", 32'(bus_rr.mem_reg_beta), 32'h00);
        reset = 1'b0;
        stray_ack = 0; stray_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_rr.core_ack || bus_rr.dma_ack) stray_ack++;
            if (busy_rr) stray_busy++;
        end
        check("stale_toggle_ack", 32'(stray_ack), 32'd0);
        check("stale_toggle_busy", 32'(stray_busy), 32'd0);

        // Spurious toggle while idle, then a load answered after four cycles
        mem_delay = 4;
        spur_req++;
        stray_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_rr.core_ack || bus_rr.dma_ack || busy_rr) stray_ack++;
        end
        check("spur_idle", 32'(stray_ack), 32'd0);
        access("spur_lw", 1'b0, 1'b0, 8'h10, 8'h00, 30);
        check("spur_latency", 32'(lat), 32'd6);
        check("spur_rdata", 32'(rd), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
